// File: rtl/rgb_palette_converter.sv
// rgb_palette_converter
//   Two-stage palette lookup with a per-request output transform.
//   A register-file palette of 2**IDX_W entries ({R,G,B}, CH_W bits each) is
//   read in stage 1 and the selected transform is applied into stage 2.
//
// Parameters
//   IDX_W : colour index width (palette depth 2**IDX_W)
//   CH_W  : width of each R/G/B channel
//
// Ports
//   clka      : clock, all state on rising edge
//   rst_n     : asynchronous active-low reset (clears pipeline, restores palette)
//   ena       : pipeline advance enable; the pipeline holds when low
//   in_valid  : lookup request strobe
//   colour    : palette index to look up
//   mode      : transform, 0 pass / 1 invert / 2 greyscale / 3 dim
//   wr_en     : palette write strobe (independent of ena/in_valid)
//   wr_addr   : palette entry to write
//   wr_data   : new palette entry {R,G,B}
//   out_valid : rgb holds a valid result
//   rgb       : converted colour {R,G,B}

// Per-channel transform. Greyscale needs all three channels, so the shared
// luma value is computed once by the parent and handed in as y.
module rpc_chan_xform #(
    parameter int CH_W = 8
) (
    input  logic [CH_W-1:0] ch,
    input  logic [CH_W-1:0] y,
    input  logic [1:0]      mode,
    output logic [CH_W-1:0] q
);
    always_comb begin
        q = ch;
        case (mode)
            2'd0:    q = ch;
            2'd1:    q = ~ch;          // (2**CH_W-1) - ch
            2'd2:    q = y;
            default: q = ch >> 1;
        endcase
    end
endmodule

module rgb_palette_converter #(
    parameter int IDX_W = 3,
    parameter int CH_W  = 8
) (
    input  logic                clka,
    input  logic                rst_n,
    input  logic                ena,
    input  logic                in_valid,
    input  logic [IDX_W-1:0]    colour,
    input  logic [1:0]          mode,
    input  logic                wr_en,
    input  logic [IDX_W-1:0]    wr_addr,
    input  logic [3*CH_W-1:0]   wr_data,
    output logic                out_valid,
    output logic [3*CH_W-1:0]   rgb
);
    localparam int DEPTH  = 2 ** IDX_W;
    localparam int RGB_W  = 3 * CH_W;
    localparam int STAGES = 2;

    typedef struct packed {
        logic [1:0]       mode;
        logic [RGB_W-1:0] data;
    } s1_t;

    // Default entry: R/G/B saturate from index bits IDX_W-1 / IDX_W-2 / IDX_W-3;
    // a channel whose bit does not exist stays 0.
    function automatic logic [RGB_W-1:0] pal_default(input int unsigned idx);
        logic [RGB_W-1:0] v;
        int               b;
        v = '0;
        for (int c = 0; c < 3; c++) begin
            b = IDX_W - 1 - c;
            if (b >= 0) begin
                if (((idx >> b) & 1) != 0)
                    v[(2-c)*CH_W +: CH_W] = '1;
            end
        end
        return v;
    endfunction

    // ---------------------------------------------------------------- palette
    logic [RGB_W-1:0] pal [DEPTH];

    for (genvar i = 0; i < DEPTH; i++) begin : g_pal
        localparam logic [RGB_W-1:0] DEF = pal_default(i);
        always_ff @(posedge clka or negedge rst_n) begin
            if (!rst_n)
                pal[i] <= DEF;
            else if (wr_en && (wr_addr == IDX_W'(i)))
                pal[i] <= wr_data;
        end
    end

    // Write-first: a same-cycle write to the looked-up entry is seen by the read.
    logic [RGB_W-1:0] rd_data;
    assign rd_data = (wr_en && (wr_addr == colour)) ? wr_data : pal[colour];

    // --------------------------------------------------------------- pipeline
    logic [STAGES:1] vld_pipe;
    s1_t             s1;
    logic [RGB_W-1:0] rgb_q;
    logic [RGB_W-1:0] xf_data;

    always_ff @(posedge clka or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            s1       <= '0;
            rgb_q    <= '0;
        end else if (ena) begin
            vld_pipe <= {vld_pipe[STAGES-1:1], in_valid};
            s1       <= '{mode: mode, data: rd_data};
            rgb_q    <= xf_data;
        end
    end

    // -------------------------------------------------------------- transform
    logic [2:0][CH_W-1:0] s1_ch;
    logic [2:0][CH_W-1:0] xf_ch;
    logic [CH_W-1:0]      luma;

    assign s1_ch = s1.data;

    // (R + 2G + B) >> 2 at CH_W+2 bits; the shifted result always fits CH_W.
    assign luma = CH_W'(({2'b00, s1_ch[2]} + {1'b0, s1_ch[1], 1'b0} + {2'b00, s1_ch[0]}) >> 2);

    for (genvar c = 0; c < 3; c++) begin : g_ch
        rpc_chan_xform #(.CH_W(CH_W)) u_xf (
            .ch   (s1_ch[c]),
            .y    (luma),
            .mode (s1.mode),
            .q    (xf_ch[c])
        );
    end

    assign xf_data   = xf_ch;
    assign out_valid = vld_pipe[STAGES];
    assign rgb       = rgb_q;

endmodule

// File: tb/tb_rgb_palette_converter.sv
module tb_rgb_palette_converter;
    localparam int IDX_W = 3;
    localparam int CH_W  = 8;
    localparam int DEPTH = 8;

    typedef struct {
        logic [23:0] rgb;
        int          due;
    } exp_t;

    logic        clka = 1'b0;
    logic        rst_n = 1'b0;
    logic        ena = 1'b0;
    logic        in_valid = 1'b0;
    logic [2:0]  colour = '0;
    logic [1:0]  mode = '0;
    logic        wr_en = 1'b0;
    logic [2:0]  wr_addr = '0;
    logic [23:0] wr_data = '0;
    logic        out_valid;
    logic [23:0] rgb;

    int          errors = 0;
    int          checks = 0;
    int          en_edge = 0;
    bit          rst_seen = 1'b0;
    logic [23:0] mpal [DEPTH];
    exp_t        exp_q [$];

    always #5 clka = ~clka;

    rgb_palette_converter #(.IDX_W(IDX_W), .CH_W(CH_W)) dut (
        .clka      (clka),
        .rst_n     (rst_n),
        .ena       (ena),
        .in_valid  (in_valid),
        .colour    (colour),
        .mode      (mode),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .out_valid (out_valid),
        .rgb       (rgb)
    );

    // Counts enabled edges; results are due two enabled edges after issue.
    always @(posedge clka) if (rst_n && ena) en_edge <= en_edge + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic [23:0] xf(input logic [23:0] e, input logic [1:0] m);
        int r, g, b, y;
        r = e[23:16]; g = e[15:8]; b = e[7:0];
        case (m)
            2'd0: return e;
            2'd1: return {8'(255 - r), 8'(255 - g), 8'(255 - b)};
            2'd2: begin
                y = (r + 2 * g + b) / 4;
                return {8'(y), 8'(y), 8'(y)};
            end
            default: return {8'(r / 2), 8'(g / 2), 8'(b / 2)};
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++)
            mpal[i] = {((i & 4) != 0) ? 8'hFF : 8'h00,
                       ((i & 2) != 0) ? 8'hFF : 8'h00,
                       ((i & 1) != 0) ? 8'hFF : 8'h00};
    endtask

    // One cycle of stimulus; expected result is the constant k when use_k,
    // otherwise the reference model.
    task automatic drive(input logic e, input logic v, input logic [2:0] c, input logic [1:0] m,
                         input logic we, input logic [2:0] wa, input logic [23:0] wd,
                         input logic use_k, input logic [23:0] k);
        logic [23:0] ent;
        exp_t        x;
        @(negedge clka);
        ena = e; in_valid = v; colour = c; mode = m;
        wr_en = we; wr_addr = wa; wr_data = wd;
        ent = (we && wa == c) ? wd : mpal[c];
        if (e && v) begin
            x.rgb = use_k ? k : xf(ent, m);
            x.due = en_edge + 2;
            exp_q.push_back(x);
        end
        if (we) mpal[wa] = wd;
    endtask

    task automatic lookup(input logic [2:0] c, input logic [1:0] m, input logic [23:0] k);
        drive(1'b1, 1'b1, c, m, 1'b0, 3'd0, 24'h0, 1'b1, k);
    endtask

    task automatic write(input logic [2:0] a, input logic [23:0] d);
        drive(1'b1, 1'b0, 3'd0, 2'd0, 1'b1, a, d, 1'b0, 24'h0);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b1, 1'b0, 3'd0, 2'd0, 1'b0, 3'd0, 24'h0, 1'b0, 24'h0);
    endtask

    // Monitor: on each enabled edge either the oldest due result or out_valid=0;
    // on stalled edges the outputs must not move.
    initial begin
        int          prev_edge;
        logic        prev_ov;
        logic [23:0] prev_rgb;
        exp_t        e;
        prev_edge = 0; prev_ov = 1'b0; prev_rgb = '0;
        forever begin
            @(posedge clka);
            #1;
            if (rst_n) begin
                if (en_edge != prev_edge) begin
                    if (exp_q.size() > 0 && exp_q[0].due == en_edge) begin
                        e = exp_q.pop_front();
                        chk("out_valid", 32'(out_valid), 32'd1);
                        chk("rgb", 32'(rgb), 32'(e.rgb));
                    end else begin
                        chk("idle_valid", 32'(out_valid), 32'd0);
                    end
                end else if (!rst_seen) begin
                    chk("stall_valid", 32'(out_valid), 32'(prev_ov));
                    chk("stall_rgb", 32'(rgb), 32'(prev_rgb));
                end
                rst_seen = 1'b0;
            end
            prev_edge = en_edge; prev_ov = out_valid; prev_rgb = rgb;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want $finish");
        $fatal(1);
    end

    initial begin
        model_reset();
        #12;
        chk("reset_valid", 32'(out_valid), 32'd0);
        chk("reset_rgb", 32'(rgb), 32'd0);
        @(negedge clka);
        rst_n = 1'b1;

        // defaults
        lookup(3'd0, 2'd0, 24'h000000);
        lookup(3'd7, 2'd0, 24'hFFFFFF);
        lookup(3'd4, 2'd0, 24'hFF0000);
        idle(2);

        // program and read
        write(3'd2, 24'h123456);
        lookup(3'd2, 2'd0, 24'h123456);
        lookup(3'd2, 2'd1, 24'hEDCBA9);
        idle(2);

        // write/lookup collision
        drive(1'b1, 1'b1, 3'd5, 2'd0, 1'b1, 3'd5, 24'hA0B0C0, 1'b1, 24'hA0B0C0);
        idle(2);

        // transforms
        write(3'd3, 24'hFF8001);
        lookup(3'd3, 2'd2, 24'h808080);
        lookup(3'd3, 2'd3, 24'h7F4000);
        idle(2);

        // stall: requests ignored while ena=0, writes still land
        lookup(3'd1, 2'd0, 24'h0000FF);
        drive(1'b0, 1'b1, 3'd7, 2'd1, 1'b0, 3'd0, 24'h0, 1'b0, 24'h0);
        drive(1'b0, 1'b0, 3'd0, 2'd0, 1'b1, 3'd4, 24'h0A0B0C, 1'b0, 24'h0);
        drive(1'b0, 1'b1, 3'd6, 2'd2, 1'b0, 3'd0, 24'h0, 1'b0, 24'h0);
        idle(2);
        lookup(3'd4, 2'd0, 24'h0A0B0C);
        idle(2);

        // reset with requests in flight
        write(3'd6, 24'h55AA33);
        lookup(3'd6, 2'd0, 24'h55AA33);
        lookup(3'd6, 2'd3, 24'h2A5519);
        @(posedge clka);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 32'(out_valid), 32'd0);
        chk("async_rst_rgb", 32'(rgb), 32'd0);
        exp_q.delete();
        model_reset();
        rst_seen = 1'b1;
        in_valid = 1'b0;
        #1 rst_n = 1'b1;
        lookup(3'd6, 2'd0, 24'hFFFF00);
        lookup(3'd2, 2'd0, 24'h00FF00);
        idle(2);

        // randomized traffic against the reference model
        repeat (400) begin
            drive(($urandom_range(0, 4) != 0), 1'($urandom), 3'($urandom), 2'($urandom),
                  ($urandom_range(0, 3) == 0), 3'($urandom), 24'($urandom), 1'b0, 24'h0);
        end
        idle(3);
        chk("drain", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
